// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: framed, checksummed UART command engine for SPI register access and debug-RAM dump
module uart_reg_bridge #(
  parameter int SPI_ADDR_WIDTH  = 6,
  parameter int SPI_DATA_WIDTH  = 20,
  parameter int RAM_ADDR_WID    = 7,
  parameter int RAM_DATA_WID    = 12,
  parameter int RX_TIMEOUT_CYC  = 660000,
  parameter int SPI_TIMEOUT_CYC = 4096
) (
  input  logic                      i_clk_sys,
  input  logic                      i_rst,
  input  logic [7:0]                i_rx_data,
  input  logic                      i_rx_done,
  input  logic                      i_tx_idle,
  output logic [7:0]                o_tx_data,
  output logic                      o_tx_valid,
  output logic                      o_spi_start,
  output logic                      o_spi_rw,
  output logic [SPI_ADDR_WIDTH-1:0] o_spi_addr,
  output logic [SPI_DATA_WIDTH-1:0] o_spi_data,
  input  logic                      i_spi_data_valid,
  input  logic [SPI_DATA_WIDTH-1:0] i_spi_data,
  output logic                      o_ram_en,
  output logic [RAM_ADDR_WID-1:0]   o_ram_addr,
  input  logic [RAM_DATA_WID-1:0]   i_ram_data,
  output logic [3:0]                o_status
);
  localparam int AB  = (SPI_ADDR_WIDTH + 7) / 8;
  localparam int DB  = (SPI_DATA_WIDTH + 7) / 8;
  localparam int RB  = (RAM_DATA_WID + 7) / 8;
  localparam int SW  = 8 * ((1 + DB) > RB ? (1 + DB) : RB);
  localparam int TW  = $clog2(RX_TIMEOUT_CYC + 1);
  localparam int STW = $clog2(SPI_TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, PAYLD, CSUM, EXEC, REPLY} state_t;
  state_t                 state_q, state_d;
  logic [7:0]             cmd_q, cmd_d, cnt_q, cnt_d, csum_q, csum_d, num_q, num_d, rlen_q, rlen_d;
  logic [8*AB-1:0]        addr_q, addr_d;
  logic [8*DB-1:0]        data_q, data_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [STW-1:0]         scnt_q, scnt_d;
  logic [SW-1:0]          sh_q, sh_d;
  logic [8:0]             words_q, words_d;
  logic [RAM_ADDR_WID-1:0] raddr_q, raddr_d;
  logic                   start_q, start_d, rd_q, rd_d, hold_q, hold_d;
  logic                   ovr_q, ovr_d, cse_q, cse_d, tmf_q, tmf_d;
  logic                   busy, frame, tx_go, ram_go;
  assign busy   = (state_q == EXEC) || (state_q == REPLY);
  assign frame  = (state_q == CMD) || (state_q == ADDR) || (state_q == PAYLD) || (state_q == CSUM);
  // a byte goes out only on idle, and never the cycle right after a strobe
  assign tx_go  = (state_q == REPLY) && (rlen_q != 8'd0) && i_tx_idle && !hold_q;
  assign ram_go = (state_q == REPLY) && (rlen_q == 8'd0) && (words_q != 9'd0) && !rd_q;
  assign o_tx_valid  = tx_go;
  assign o_tx_data   = sh_q[SW-1 -: 8];
  assign o_ram_en    = ram_go;
  assign o_ram_addr  = raddr_q;
  assign o_spi_start = start_q;
  assign o_spi_rw    = (cmd_q == 8'h02);
  assign o_spi_addr  = addr_q[SPI_ADDR_WIDTH-1:0];
  assign o_spi_data  = data_q[SPI_DATA_WIDTH-1:0];
  assign o_status    = {ovr_q, cse_q, tmf_q, busy};
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    num_d   = num_q;
    rlen_d  = rlen_q;
    addr_d  = addr_q;
    data_d  = data_q;
    tmo_d   = frame ? (i_rx_done ? '0 : tmo_q + 1'b1) : '0;
    scnt_d  = scnt_q;
    sh_d    = sh_q;
    words_d = words_q;
    raddr_d = raddr_q;
    start_d = 1'b0;
    rd_d    = rd_q;
    hold_d  = tx_go;
    ovr_d   = ovr_q | (busy & i_rx_done);
    cse_d   = cse_q;
    tmf_d   = tmf_q;
    if (frame && !i_rx_done && tmo_q == TW'(RX_TIMEOUT_CYC)) begin
      state_d = IDLE;
      tmf_d   = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = (i_rx_done && i_rx_data == 8'hA5) ? CMD : IDLE;
        CMD: if (i_rx_done) begin
          cmd_d  = i_rx_data;
          csum_d = i_rx_data;
          cnt_d  = 8'd0;
          if (i_rx_data == 8'h01 || i_rx_data == 8'h02 || i_rx_data == 8'h03) state_d = ADDR;
          else begin
            state_d = REPLY;
            sh_d    = SW'({8'hEE, 8'h01}) << (SW - 16);
            rlen_d  = 8'd2;
          end
        end
        ADDR: if (i_rx_done) begin
          addr_d = (addr_q << 8) | (8*AB)'(i_rx_data);
          csum_d = csum_q ^ i_rx_data;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q == 8'(AB - 1)) begin
            cnt_d   = 8'd0;
            state_d = (cmd_q == 8'h02) ? CSUM : PAYLD;
          end
        end
        PAYLD: if (i_rx_done) begin
          csum_d = csum_q ^ i_rx_data;
          cnt_d  = cnt_q + 8'd1;
          if (cmd_q == 8'h01) data_d = (data_q << 8) | (8*DB)'(i_rx_data);
          else num_d = i_rx_data;
          if (cmd_q != 8'h01 || cnt_q == 8'(DB - 1)) begin
            cnt_d   = 8'd0;
            state_d = CSUM;
          end
        end
        CSUM: if (i_rx_done) begin
          if (i_rx_data == csum_q) begin
            state_d = EXEC;
            start_d = (cmd_q != 8'h03);
            scnt_d  = '0;
          end else begin
            state_d = REPLY;
            sh_d    = SW'({8'hEE, 8'h02}) << (SW - 16);
            rlen_d  = 8'd2;
            cse_d   = 1'b1;
          end
        end
        EXEC: if (cmd_q == 8'h03) begin
          state_d = REPLY;
          sh_d    = SW'(8'h5A) << (SW - 8);
          rlen_d  = 8'd1;
          words_d = (num_q == 8'd0) ? 9'd256 : {1'b0, num_q};
          raddr_d = RAM_ADDR_WID'(addr_q);
          rd_d    = 1'b0;
        end else if (i_spi_data_valid) begin
          state_d = REPLY;
          sh_d    = SW'({8'h5A, (8*DB)'(i_spi_data)}) << (SW - 8*(1 + DB));
          rlen_d  = (cmd_q == 8'h02) ? 8'(1 + DB) : 8'd1;
        end else if (scnt_q == STW'(SPI_TIMEOUT_CYC - 1)) begin
          state_d = REPLY;
          sh_d    = SW'({8'hEE, 8'h03}) << (SW - 16);
          rlen_d  = 8'd2;
          tmf_d   = 1'b1;
        end else scnt_d = scnt_q + 1'b1;
        REPLY: if (tx_go) begin
          sh_d   = sh_q << 8;
          rlen_d = rlen_q - 8'd1;
        end else if (rd_q) begin
          sh_d    = SW'((8*RB)'(i_ram_data)) << (SW - 8*RB);
          rlen_d  = 8'(RB);
          words_d = words_q - 9'd1;
          raddr_d = raddr_q + 1'b1;
          rd_d    = 1'b0;
        end else if (ram_go) rd_d = 1'b1;
        else if (rlen_q == 8'd0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      cmd_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      num_q   <= '0;
      rlen_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      tmo_q   <= '0;
      scnt_q  <= '0;
      sh_q    <= '0;
      words_q <= '0;
      raddr_q <= '0;
      start_q <= 1'b0;
      rd_q    <= 1'b0;
      hold_q  <= 1'b0;
      ovr_q   <= 1'b0;
      cse_q   <= 1'b0;
      tmf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      num_q   <= num_d;
      rlen_q  <= rlen_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      scnt_q  <= scnt_d;
      sh_q    <= sh_d;
      words_q <= words_d;
      raddr_q <= raddr_d;
      start_q <= start_d;
      rd_q    <= rd_d;
      hold_q  <= hold_d;
      ovr_q   <= ovr_d;
      cse_q   <= cse_d;
      tmf_q   <= tmf_d;
    end
  end
  logic unused;
  assign unused = ^{addr_q, data_q};
endmodule
